clause_load_sequencer: RTL and testbench

- Sequencer in front of UnsatisfiedClauses.
- On a start request it streams N clause coefficient words from the formula memory into the checker's clause registers, one clause index at a time.
- It then enables the loaded clauses' checkers, waits a settle window, and samples the formula satisfaction result.
- It replaces the hand-driven clause loading used in bench-level sequencing and is the handoff point to the MCMC top-level controller.

---
 rtl/clause_load_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_clause_load_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clause_load_sequencer.sv
// Clause load sequencer: streams clause coefficient words from the formula
// memory into the UnsatisfiedClauses registers, enables the loaded checkers
// for a settle window, then samples the formula satisfaction result.
module clause_load_sequencer #(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 1,
  parameter int CHECK_SETTLE_CYCLES                         = 2,
  localparam int IW = (2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX + 1) *
                      MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
  localparam int BW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT *
                      2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
  localparam int CW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int NC = 2**CW
) (
  input  logic          in_clk,
  input  logic          in_reset,
  input  logic          in_start,
  input  logic [CW:0]   in_num_clauses,
  output logic [CW-1:0] out_mem_addr,
  output logic          out_mem_read_enable,
  input  logic [IW-1:0] in_mem_integer_data,
  input  logic [BW-1:0] in_mem_boolean_data,
  output logic [IW-1:0] out_clause_coefficients_integer,
  output logic [BW-1:0] out_clause_coefficients_boolean,
  output logic [CW-1:0] out_clause_index,
  output logic          out_clause_write_enable,
  output logic [NC-1:0] out_checker_enable,
  input  logic          in_satisfied,
  output logic          out_busy,
  output logic          out_done,
  output logic          out_formula_satisfied
);

  localparam logic [CW:0]   NC_COUNT    = (CW+1)'(NC);
  localparam logic [CW-1:0] IDX_MAX     = CW'(NC - 1);
  localparam logic [3:0]    SETTLE_LOAD = 4'(CHECK_SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_idx;
  logic [CW:0]   r_num;
  logic [3:0]    r_settle;
  logic [IW-1:0] r_coef_int;
  logic [BW-1:0] r_coef_bool;
  logic [CW-1:0] r_clause_index;
  logic          r_formula_sat;
  logic [CW:0]   w_num_clamped;
  logic          w_last;
  logic [NC-1:0] w_mask;

  // Clamp the requested clause count, detect the last clause, build the enable mask.
  always_comb begin
    w_num_clamped = in_num_clauses;
    if (in_num_clauses > NC_COUNT) begin
      w_num_clamped = NC_COUNT;
    end else begin
      w_num_clamped = in_num_clauses;
    end
    // The IDX_MAX term keeps idx from ever wrapping, independent of r_num.
    w_last = ({1'b0, r_idx} == (r_num - (CW+1)'(1))) || (r_idx == IDX_MAX);
    w_mask = {NC{1'b0}};
    for (int i = 0; i < NC; i++) begin
      w_mask[i] = ((CW+1)'(i) < r_num);
    end
  end

  // State register.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_start) begin
          if (in_num_clauses == {(CW+1){1'b0}}) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_READ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ:  w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (w_last) begin
          w_state_nxt = ST_SETTLE;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_SETTLE: begin
        if (r_settle <= 4'd1) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_CHECK: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Clause counter, settle counter, held coefficient/index values and sampled result.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_idx          <= {CW{1'b0}};
      r_num          <= {(CW+1){1'b0}};
      r_settle       <= 4'd0;
      r_coef_int     <= {IW{1'b0}};
      r_coef_bool    <= {BW{1'b0}};
      r_clause_index <= {CW{1'b0}};
      r_formula_sat  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_start) begin
            r_idx <= {CW{1'b0}};
            r_num <= w_num_clamped;
            // An empty formula is trivially satisfied.
            if (in_num_clauses == {(CW+1){1'b0}}) begin
              r_formula_sat <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_coef_int     <= in_mem_integer_data;
          r_coef_bool    <= in_mem_boolean_data;
          r_clause_index <= r_idx;
          if (w_last) begin
            r_settle <= SETTLE_LOAD;
          end else begin
            r_idx <= r_idx + CW'(1);
          end
        end
        ST_SETTLE: r_settle <= r_settle - 4'd1;
        ST_CHECK:  r_formula_sat <= in_satisfied;
        default: ;
      endcase
    end
  end

  // Output decode from the registered state; WRITE forwards memory data directly
  // because it only becomes valid in that cycle.
  always_comb begin
    out_mem_addr                    = r_idx;
    out_mem_read_enable             = 1'b0;
    out_clause_coefficients_integer = r_coef_int;
    out_clause_coefficients_boolean = r_coef_bool;
    out_clause_index                = r_clause_index;
    out_clause_write_enable         = 1'b0;
    out_checker_enable              = {NC{1'b0}};
    out_busy                        = (r_state != ST_IDLE);
    out_done                        = 1'b0;
    out_formula_satisfied           = r_formula_sat;
    case (r_state)
      ST_READ: out_mem_read_enable = 1'b1;
      ST_WRITE: begin
        out_clause_coefficients_integer = in_mem_integer_data;
        out_clause_coefficients_boolean = in_mem_boolean_data;
        out_clause_index                = r_idx;
        out_clause_write_enable         = 1'b1;
      end
      ST_SETTLE: out_checker_enable = w_mask;
      ST_CHECK:  out_checker_enable = w_mask;
      ST_DONE:   out_done           = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clause_load_sequencer.sv
// Randomized scoreboard bench for clause_load_sequencer.
module tb_clause_load_sequencer;
  localparam int IW = 12;
  localparam int BW = 4;
  localparam int CW = 1;
  localparam int NC = 2;
  localparam int S  = 2;

  logic          in_clk;
  logic          in_reset;
  logic          in_start;
  logic [CW:0]   in_num_clauses;
  logic [CW-1:0] out_mem_addr;
  logic          out_mem_read_enable;
  logic [IW-1:0] in_mem_integer_data;
  logic [BW-1:0] in_mem_boolean_data;
  logic [IW-1:0] out_clause_coefficients_integer;
  logic [BW-1:0] out_clause_coefficients_boolean;
  logic [CW-1:0] out_clause_index;
  logic          out_clause_write_enable;
  logic [NC-1:0] out_checker_enable;
  logic          in_satisfied;
  logic          out_busy;
  logic          out_done;
  logic          out_formula_satisfied;

  clause_load_sequencer dut (
    .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
    .in_num_clauses(in_num_clauses), .out_mem_addr(out_mem_addr),
    .out_mem_read_enable(out_mem_read_enable),
    .in_mem_integer_data(in_mem_integer_data), .in_mem_boolean_data(in_mem_boolean_data),
    .out_clause_coefficients_integer(out_clause_coefficients_integer),
    .out_clause_coefficients_boolean(out_clause_coefficients_boolean),
    .out_clause_index(out_clause_index), .out_clause_write_enable(out_clause_write_enable),
    .out_checker_enable(out_checker_enable), .in_satisfied(in_satisfied),
    .out_busy(out_busy), .out_done(out_done), .out_formula_satisfied(out_formula_satisfied)
  );

  typedef struct {
    int            cyc;
    int            idx;
    logic [IW-1:0] di;
    logic [BW-1:0] db;
  } wr_t;

  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  bit            mon_en = 1'b0;
  int            model_free = 0;
  logic          exp_fs = 1'b0;
  logic [IW-1:0] mem_int [NC];
  logic [BW-1:0] mem_bool[NC];
  wr_t           wq[$];
  int            dq[$];
  int            exp_rd[int];
  logic [NC-1:0] exp_mask[int];
  bit            exp_busy[int];
  int            exp_fsrc[int];
  bit            sat_hist[int];

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  // Formula memory model: data valid one cycle after the read strobe, garbage otherwise.
  always @(posedge in_clk) begin
    if (out_mem_read_enable) begin
      in_mem_integer_data <= mem_int[out_mem_addr];
      in_mem_boolean_data <= mem_bool[out_mem_addr];
    end else begin
      in_mem_integer_data <= IW'($urandom);
      in_mem_boolean_data <= BW'($urandom);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; when the reference model is idle a start is accepted
  // and the whole expected transaction timeline is pushed to the scoreboard.
  // Cycle a is the first cycle after the accepting edge.
  task automatic drive(input bit st, input int num, input bit sat, input bit keep_mem);
    int a, n, d;
    @(negedge in_clk);
    in_start       = st;
    in_num_clauses = num[CW:0];
    in_satisfied   = sat;
    sat_hist[cyc]  = sat;
    if (st && cyc >= model_free) begin
      if (!keep_mem) begin
        for (int k = 0; k < NC; k++) begin
          mem_int[k]  = IW'($urandom);
          mem_bool[k] = BW'($urandom);
        end
      end
      a = cyc + 1;
      n = (num > NC) ? NC : num;
      if (n == 0) begin
        d = a;
      end else begin
        for (int k = 0; k < n; k++) begin
          exp_rd[a + 2*k] = k;
          wq.push_back('{a + 2*k + 1, k, mem_int[k], mem_bool[k]});
        end
        for (int c = a + 2*n; c <= a + 2*n + S; c++) exp_mask[c] = NC'((1 << n) - 1);
        d = a + 2*n + S + 1;
      end
      for (int c = a; c <= d; c++) exp_busy[c] = 1'b1;
      dq.push_back(d);
      exp_fsrc[d] = n;
      model_free  = d + 1;
    end
  endtask

  task automatic flush_model();
    wq.delete(); dq.delete(); exp_rd.delete(); exp_mask.delete();
    exp_busy.delete(); exp_fsrc.delete();
    exp_fs = 1'b0;
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  initial begin
    wr_t w;
    bit  e;
    forever begin
      @(posedge in_clk);
      #1;
      if (mon_en) begin
        e = (wq.size() > 0) && (wq[0].cyc == cyc);
        chk("write_enable", 32'(out_clause_write_enable), 32'(e));
        if (e) begin
          w = wq.pop_front();
          chk("clause_index", 32'(out_clause_index), 32'(w.idx));
          chk("coef_integer", 32'(out_clause_coefficients_integer), 32'(w.di));
          chk("coef_boolean", 32'(out_clause_coefficients_boolean), 32'(w.db));
        end
        while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
        chk("mem_read_enable", 32'(out_mem_read_enable), 32'(exp_rd.exists(cyc)));
        if (exp_rd.exists(cyc)) chk("mem_addr", 32'(out_mem_addr), 32'(exp_rd[cyc]));
        chk("checker_enable", 32'(out_checker_enable),
            exp_mask.exists(cyc) ? 32'(exp_mask[cyc]) : 32'd0);
        chk("busy", 32'(out_busy), 32'(exp_busy.exists(cyc)));
        e = (dq.size() > 0) && (dq[0] == cyc);
        chk("done", 32'(out_done), 32'(e));
        if (e) void'(dq.pop_front());
        while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
        if (exp_fsrc.exists(cyc)) exp_fs = (exp_fsrc[cyc] == 0) ? 1'b1 : sat_hist[cyc - 1];
        chk("formula_satisfied", 32'(out_formula_satisfied), 32'(exp_fs));
      end
    end
  end

  initial begin
    int guard;
    in_reset = 1'b0; in_start = 1'b0; in_num_clauses = '0; in_satisfied = 1'b0;
    for (int k = 0; k < NC; k++) begin mem_int[k] = '0; mem_bool[k] = '0; end
    repeat (3) @(negedge in_clk);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_write_enable", 32'(out_clause_write_enable), 32'd0);
    chk("rst_read_enable", 32'(out_mem_read_enable), 32'd0);
    chk("rst_checker_enable", 32'(out_checker_enable), 32'd0);
    chk("rst_formula_sat", 32'(out_formula_satisfied), 32'd0);
    chk("rst_clause_index", 32'(out_clause_index), 32'd0);
    chk("rst_coef_integer", 32'(out_clause_coefficients_integer), 32'd0);
    in_reset = 1'b1; model_free = cyc; mon_en = 1'b1;

    // Two clauses with fixed contents; a start pulse while busy is ignored.
    mem_int[0] = 12'h123; mem_bool[0] = 4'b1001;
    mem_int[1] = 12'hA5F; mem_bool[1] = 4'b0110;
    drive(1'b1, 2, 1'b1, 1'b1);
    drive(1'b0, 2, 1'b1, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b1);
    drive(1'b1, 1, 1'b1, 1'b1);
    repeat (8) drive(1'b0, 3, 1'b1, 1'b1);
    // Clamped count behaves like two clauses.
    drive(1'b1, 3, 1'b1, 1'b1);
    repeat (10) drive(1'b0, 0, 1'b1, 1'b1);
    // Single clause, unsatisfied.
    drive(1'b1, 1, 1'b0, 1'b1);
    repeat (8) drive(1'b0, 2, 1'b0, 1'b1);
    // Empty formula.
    drive(1'b1, 0, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 0, 1'b0, 1'b1);
    // Start held high: back-to-back sequences with random results.
    repeat (30) drive(1'b1, 2, 1'($urandom_range(0, 1)), 1'b0);
    repeat (10) drive(1'b0, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the clause-0 write.
    drive(1'b1, 2, 1'b1, 1'b0);
    @(negedge in_clk);
    in_start = 1'b0;
    @(negedge in_clk);
    chk("pre_reset_write_enable", 32'(out_clause_write_enable), 32'd1);
    mon_en = 1'b0;
    in_reset = 1'b0;
    #1;
    chk("async_write_enable", 32'(out_clause_write_enable), 32'd0);
    chk("async_busy", 32'(out_busy), 32'd0);
    chk("async_checker_enable", 32'(out_checker_enable), 32'd0);
    flush_model();
    @(negedge in_clk);
    in_reset = 1'b1; model_free = cyc; mon_en = 1'b1;

    // Randomized traffic.
    repeat (600) drive(($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'b0);

    // Drain with a bounded wait.
    guard = 0;
    while ((wq.size() > 0 || dq.size() > 0) && guard < 40) begin
      drive(1'b0, 0, 1'b0, 1'b0);
      guard++;
    end
    repeat (2) drive(1'b0, 0, 1'b0, 1'b0);
    tests++;
    if (wq.size() > 0 || dq.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout pending_writes=%0d pending_done=%0d required=0",
               wq.size(), dq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
